// File: rtl/sm4_cbc_stream.sv
// Byte-serial SM4-CBC wrapper around an external combinational SM4 core.
// Buffers one 16-byte block, transforms it in one cycle, then drains it byte by byte.
module sm4_cbc_stream (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [0:15][7:0] cfg_iv,
  input  logic             cfg_mode,
  output logic             cfg_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [0:15][7:0] core_src,
  output logic             core_mode,
  input  logic [0:15][7:0] core_dst,
  output logic             busy
);

  typedef enum logic [1:0] {StFill, StXform, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       ocnt_q, ocnt_d;
  logic [0:15][7:0] in_buf_q, in_buf_d;
  logic [0:15][7:0] out_buf_q, out_buf_d;
  logic [0:15][7:0] chain_q, chain_d;
  logic             mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      cnt_q     <= 4'd0;
      ocnt_q    <= 4'd0;
      in_buf_q  <= '0;
      out_buf_q <= '0;
      chain_q   <= '0;
      mode_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ocnt_q    <= ocnt_d;
      in_buf_q  <= in_buf_d;
      out_buf_q <= out_buf_d;
      chain_q   <= chain_d;
      mode_q    <= mode_d;
    end
  end

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StDrain);
  assign cfg_ready = (state_q == StFill) && (cnt_q == 4'd0);
  assign busy      = !cfg_ready;
  assign out_data  = out_buf_q[ocnt_q];
  assign core_mode = mode_q;
  // Encrypt pre-whitens with the chain; decrypt post-whitens in XFORM.
  assign core_src  = mode_q ? (in_buf_q ^ chain_q) : in_buf_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ocnt_d    = ocnt_q;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    chain_d   = chain_q;
    mode_d    = mode_q;

    if (cfg_load && cfg_ready) begin
      chain_d = cfg_iv;
      mode_d  = cfg_mode;
    end

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          in_buf_d[cnt_q] = in_data;
          cnt_d           = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = StXform;
        end
      end
      StXform: begin
        if (mode_q) begin
          out_buf_d = core_dst;
          chain_d   = core_dst;
        end else begin
          out_buf_d = core_dst ^ chain_q;
          chain_d   = in_buf_q;
        end
        state_d = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          ocnt_d = ocnt_q + 4'd1;
          if (ocnt_q == 4'd15) state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

endmodule

// File: tb/tb_sm4_cbc_stream.sv
// Bench for sm4_cbc_stream: models the SM4 core and checks output bytes against a
// scoreboard filled by an independent CBC model.
module tb_sm4_cbc_stream;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_load, cfg_mode, cfg_ready;
  logic [0:15][7:0] cfg_iv;
  logic             in_valid, in_ready, out_valid, out_ready, busy, core_mode;
  logic [7:0]       in_data, out_data;
  logic [0:15][7:0] core_src, core_dst;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [127:0] m_chain;
  logic        m_mode;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [127:0] sm4(input logic [127:0] blk, input logic enc,
                                       input logic [127:0] key);
    logic [31:0] k [0:35];
    logic [31:0] rk [0:31];
    logic [31:0] x [0:35];
    logic [31:0] t, ck;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4 * i) * 7), 8'((4 * i + 1) * 7), 8'((4 * i + 2) * 7), 8'((4 * i + 3) * 7)};
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      rk[i] = k[i+4];
    end
    x[0] = blk[127:96];
    x[1] = blk[95:64];
    x[2] = blk[63:32];
    x[3] = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (enc ? rk[i] : rk[31-i]));
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  sm4_cbc_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_iv    (cfg_iv),
    .cfg_mode  (cfg_mode),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .core_src  (core_src),
    .core_mode (core_mode),
    .core_dst  (core_dst),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  assign core_dst = sm4(core_src, core_mode, KEY);

  task automatic model_reset();
    m_chain = '0;
    m_mode  = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_cfg(input logic [127:0] iv, input logic mode);
    cfg_load = 1'b1;
    cfg_iv   = iv;
    cfg_mode = mode;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_idle: got %b, expected 1", cfg_ready);
    end
    @(negedge clk);
    cfg_load = 1'b0;
    m_chain  = iv;
    m_mode   = mode;
  endtask

  // Streams one block; optionally pulses cfg_load alongside byte cfg_at.
  task automatic send_block(input logic [127:0] blk, input int cfg_at,
                            input logic [127:0] iv, input logic mode);
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      int cyc;
      in_valid = 1'b1;
      in_data  = blk[127-8*i -: 8];
      cfg_load = (i == cfg_at);
      cfg_iv   = iv;
      cfg_mode = mode;
      cyc = 0;
      while (!in_ready && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (!in_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout byte %0d: got 0, expected 1", i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    cfg_load = 1'b0;
    if (cfg_at == 0) begin
      m_chain = iv;
      m_mode  = mode;
    end
    if (m_mode) begin
      res     = sm4(blk ^ m_chain, 1'b1, KEY);
      m_chain = res;
    end else begin
      res     = sm4(blk, 1'b0, KEY) ^ m_chain;
      m_chain = blk;
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(res[127-8*i -: 8]);
  endtask

  task automatic drain_block(input int stall_at, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < 16; i++) begin
      int cyc;
      logic [7:0] exp;
      out_ready = 1'b1;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (!out_valid) begin
        n_fail++;
        $display("FAIL out_valid_timeout byte %0d: got 0, expected 1", i);
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty byte %0d: got %h, expected none", i, out_data);
        exp = 8'h00;
      end else begin
        exp = exp_q.pop_front();
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL out_byte %0d: got %h, expected %h", i, out_data, exp);
        end
      end
      got[127-8*i -: 8] = out_data;
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_checks++;
          if (out_data !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall cycle %0d: got data=%h valid=%b in_ready=%b, expected %h 1 0",
                     s, out_data, out_valid, in_ready, exp);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0 ||
        core_src !== '0 || core_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b cr=%b busy=%b src=%h mode=%b, expected 0 1 1 0 0 1",
               out_valid, in_ready, cfg_ready, busy, core_src, core_mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_encrypt_kat();
    logic [127:0] got;
    do_cfg(128'h0, 1'b1);
    send_block(KEY, -1, '0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_xform: got ov=%b busy=%b, expected 0 1", out_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_drain: got ov=%b, expected 1", out_valid);
    end
    drain_block(-1, got);
    n_checks++;
    if (got !== 128'h681edf34d206965e86b3e94f536e4246) begin
      n_fail++;
      $display("FAIL enc_kat: got %h, expected 681edf34d206965e86b3e94f536e4246", got);
    end
  endtask

  task automatic test_decrypt_kat();
    logic [127:0] got;
    do_cfg(128'h0, 1'b0);
    send_block(128'h681edf34d206965e86b3e94f536e4246, -1, '0, 1'b0);
    drain_block(-1, got);
    n_checks++;
    if (got !== KEY) begin
      n_fail++;
      $display("FAIL dec_kat: got %h, expected %h", got, KEY);
    end
  endtask

  task automatic test_cbc_roundtrip();
    logic [127:0] iv, p, c1, c2, p1, p2;
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    p  = 128'h00112233445566778899aabbccddeeff;
    do_cfg(iv, 1'b1);
    send_block(p, -1, '0, 1'b0);
    drain_block(-1, c1);
    send_block(p, -1, '0, 1'b0);
    drain_block(-1, c2);
    n_checks++;
    if (c1 === c2) begin
      n_fail++;
      $display("FAIL cbc_distinct: got c2=%h, expected different from c1=%h", c2, c1);
    end
    n_checks++;
    if (c1 !== sm4(p ^ iv, 1'b1, KEY)) begin
      n_fail++;
      $display("FAIL cbc_c1: got %h, expected %h", c1, sm4(p ^ iv, 1'b1, KEY));
    end
    n_checks++;
    if (c2 !== sm4(p ^ c1, 1'b1, KEY)) begin
      n_fail++;
      $display("FAIL cbc_c2: got %h, expected %h", c2, sm4(p ^ c1, 1'b1, KEY));
    end
    do_cfg(iv, 1'b0);
    send_block(c1, -1, '0, 1'b0);
    drain_block(-1, p1);
    send_block(c2, -1, '0, 1'b0);
    drain_block(-1, p2);
    n_checks++;
    if (p1 !== p || p2 !== p) begin
      n_fail++;
      $display("FAIL cbc_roundtrip: got %h %h, expected %h", p1, p2, p);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] got;
    do_cfg(128'h0f0e0d0c0b0a09080706050403020100, 1'b1);
    send_block(128'hdeadbeefcafef00d0011223344556677, -1, '0, 1'b0);
    drain_block(7, got);
  endtask

  task automatic test_config();
    logic [127:0] iva, ivb, blk, got;
    iva = 128'h11111111222222223333333344444444;
    ivb = 128'haaaaaaaabbbbbbbbccccccccdddddddd;
    blk = 128'h0123456789abcdef0011223344556677;
    do_cfg(iva, 1'b1);
    send_block(blk, 3, ivb, 1'b0);
    drain_block(-1, got);
    n_checks++;
    if (got !== sm4(blk ^ iva, 1'b1, KEY)) begin
      n_fail++;
      $display("FAIL cfg_midblock_ignored: got %h, expected %h", got, sm4(blk ^ iva, 1'b1, KEY));
    end
    send_block(blk, 0, ivb, 1'b0);
    drain_block(-1, got);
    n_checks++;
    if (got !== (sm4(blk, 1'b0, KEY) ^ ivb)) begin
      n_fail++;
      $display("FAIL cfg_first_byte: got %h, expected %h", got, sm4(blk, 1'b0, KEY) ^ ivb);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] blk, got;
    blk = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;
    do_cfg(128'h99999999999999999999999999999999, 1'b0);
    send_block(blk, -1, '0, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ov=%b ir=%b cr=%b busy=%b, expected 0 1 1 0",
               out_valid, in_ready, cfg_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_checks++;
    if (core_src !== '0 || core_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_src: got %h mode=%b, expected 0 1", core_src, core_mode);
    end
    send_block(blk, -1, '0, 1'b0);
    drain_block(-1, got);
    n_checks++;
    if (got !== sm4(blk, 1'b1, KEY)) begin
      n_fail++;
      $display("FAIL post_reset_chain: got %h, expected %h", got, sm4(blk, 1'b1, KEY));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_load  = 1'b0;
    cfg_iv    = '0;
    cfg_mode  = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_encrypt_kat();
    test_decrypt_kat();
    test_cbc_roundtrip();
    test_backpressure();
    test_config();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
